// File: rtl/div_pkg.sv
// div_pkg: shared width, counter width and FSM state encoding for div_seq_32by16
package div_pkg;
    localparam int BIT = 16;
    localparam int CW  = $clog2(2 * BIT);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/div_seq_32by16_if.sv
// div_seq_32by16_if: start/done request bus; master drives start/dividend/divisor, slave returns busy/done/quo/rem/dz/ovf
interface div_seq_32by16_if;
    import div_pkg::*;
    logic                    start;
    logic signed [2*BIT-1:0] dividend;
    logic signed [BIT-1:0]   divisor;
    logic                    busy;
    logic                    done;
    logic signed [2*BIT-1:0] quo;
    logic signed [BIT-1:0]   rem;
    logic                    dz;
    logic                    ovf;
    modport master (output start, dividend, divisor, input busy, done, quo, rem, dz, ovf);
    modport slave  (input start, dividend, divisor, output busy, done, quo, rem, dz, ovf);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring iteration; ports pr/in_bit/dvs in, pr_nxt/q out
module div_step #(
    parameter int W = div_pkg::BIT
) (
    input  logic [W:0]   pr,
    input  logic         in_bit,
    input  logic [W-1:0] dvs,
    output logic [W:0]   pr_nxt,
    output logic         q
);
    logic [W:0]   sh;
    logic [W+1:0] trial;
    assign sh     = {pr[W-1:0], in_bit};
    assign trial  = {1'b0, sh} - {2'b00, dvs};
    assign q      = ~trial[W+1];
    assign pr_nxt = q ? trial[W:0] : sh;
endmodule

// File: rtl/div_seq_32by16.sv
// div_seq_32by16: sequential signed restoring 32/16 divider; ports clk, rst_n (async low), bus (slave: start/dividend/divisor in, busy/done/quo/rem/dz/ovf out)
module div_seq_32by16
    import div_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    div_seq_32by16_if.slave bus
);
    state_t           st_q, st_d;
    logic [2*BIT-1:0] qm_q, qm_d, quo_q, quo_d;
    logic [BIT:0]     pr_q, pr_d, pr_nxt;
    logic [BIT-1:0]   dvs_q, dvs_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sq_q, sq_d, sr_q, sr_d, dzp_q, dzp_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d, ovf_q, ovf_d, qb;
    div_step #(.W(BIT)) u_step (
        .pr     (pr_q),
        .in_bit (qm_q[2*BIT-1]),
        .dvs    (dvs_q),
        .pr_nxt (pr_nxt),
        .q      (qb)
    );
    always_comb begin
        st_d   = st_q;
        qm_d   = qm_q;
        pr_d   = pr_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        sq_d   = sq_q;
        sr_d   = sr_q;
        dzp_d  = dzp_q;
        busy_d = busy_q;
        done_d = 1'b0;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        case (st_q)
            IDLE: if (bus.start) begin
                st_d   = bus.divisor == '0 ? FIX : CALC;
                dzp_d  = bus.divisor == '0;
                busy_d = 1'b1;
                qm_d   = bus.dividend[2*BIT-1] ? -bus.dividend : bus.dividend;
                dvs_d  = bus.divisor[BIT-1] ? -bus.divisor : bus.divisor;
                sq_d   = bus.dividend[2*BIT-1] ^ bus.divisor[BIT-1];
                sr_d   = bus.dividend[2*BIT-1];
                pr_d   = '0;
                cnt_d  = CW'(2 * BIT - 1);
            end
            CALC: begin
                // quotient bits enter at the LSB as dividend bits leave the MSB
                pr_d  = pr_nxt;
                qm_d  = {qm_q[2*BIT-2:0], qb};
                cnt_d = cnt_q - 1'b1;
                st_d  = cnt_q == '0 ? FIX : CALC;
            end
            FIX: begin
                quo_d  = dzp_q ? '0 : sq_q ? -qm_q : qm_q;
                rem_d  = dzp_q ? '0 : sr_q ? -pr_q[BIT-1:0] : pr_q[BIT-1:0];
                dz_d   = dzp_q;
                ovf_d  = !dzp_q && !sq_q && qm_q == {1'b1, {(2*BIT-1){1'b0}}};
                done_d = 1'b1;
                busy_d = 1'b0;
                st_d   = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            qm_q   <= '0;
            pr_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            sq_q   <= 1'b0;
            sr_q   <= 1'b0;
            dzp_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            qm_q   <= qm_d;
            pr_q   <= pr_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            sq_q   <= sq_d;
            sr_q   <= sr_d;
            dzp_q  <= dzp_d;
            busy_q <= busy_d;
            done_q <= done_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.quo  = quo_q;
    assign bus.rem  = rem_q;
    assign bus.dz   = dz_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_div_seq_32by16.sv
// tb_div_seq_32by16: directed and reference-model checks of div_seq_32by16
module tb_div_seq_32by16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int chk = 0;
    int pass = 0;
    div_seq_32by16_if bus();
    div_seq_32by16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic run(input logic [31:0] a, input logic [15:0] b, output int lat);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk++;
        if ({bus.busy, bus.done, bus.dz, bus.ovf} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.done, bus.dz, bus.ovf});
        else pass++;
        chk++;
        if ({bus.quo, bus.rem} !== 48'h0) $display("FAIL reset_data got %h want 0", {bus.quo, bus.rem});
        else pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        run(32'd1000, 16'd7, lat);
        chk++;
        if (lat !== 33) $display("FAIL basic_latency got %0d want 33", lat);
        else pass++;
        chk++;
        if (bus.quo !== 32'd142 || bus.rem !== 16'd6) $display("FAIL basic_result got %h/%h want 0000008e/0006", bus.quo, bus.rem);
        else pass++;
        chk++;
        if ({bus.dz, bus.ovf, bus.busy} !== 3'b000) $display("FAIL basic_flags got %b want 000", {bus.dz, bus.ovf, bus.busy});
        else pass++;
        @(posedge clk);
        #1;
        chk++;
        if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", bus.done);
        else pass++;
    endtask

    task automatic test_signs;
        int lat;
        run(-32'sd1000, 16'd7, lat);
        chk++;
        if (bus.quo !== 32'hFFFFFF72 || bus.rem !== 16'hFFFA || lat !== 33) $display("FAIL neg_dividend got %h/%h lat %0d want ffffff72/fffa lat 33", bus.quo, bus.rem, lat);
        else pass++;
        run(32'd1000, 16'hFFF9, lat);
        chk++;
        if (bus.quo !== 32'hFFFFFF72 || bus.rem !== 16'h0006) $display("FAIL neg_divisor got %h/%h want ffffff72/0006", bus.quo, bus.rem);
        else pass++;
    endtask

    task automatic test_overflow;
        int lat;
        run(32'h80000000, 16'hFFFF, lat);
        chk++;
        if (bus.quo !== 32'h80000000 || bus.ovf !== 1'b1 || bus.dz !== 1'b0) $display("FAIL ovf_case got %h ovf %b dz %b want 80000000 ovf 1 dz 0", bus.quo, bus.ovf, bus.dz);
        else pass++;
        run(32'h80000000, 16'h8000, lat);
        chk++;
        if (bus.quo !== 32'd65536 || bus.rem !== 16'd0 || bus.ovf !== 1'b0) $display("FAIL min_by_min got %h/%h ovf %b want 00010000/0000 ovf 0", bus.quo, bus.rem, bus.ovf);
        else pass++;
    endtask

    task automatic test_div_zero;
        int lat;
        run(32'd5, 16'd0, lat);
        chk++;
        if (lat !== 1) $display("FAIL dz_latency got %0d want 1", lat);
        else pass++;
        chk++;
        if ({bus.quo, bus.rem} !== 48'h0 || bus.dz !== 1'b1 || bus.ovf !== 1'b0 || bus.busy !== 1'b0) $display("FAIL dz_result got %h/%h dz %b ovf %b busy %b want 0/0 dz 1 ovf 0 busy 0", bus.quo, bus.rem, bus.dz, bus.ovf, bus.busy);
        else pass++;
    endtask

    task automatic test_start_while_busy;
        int dones = 0;
        int at = -1;
        bus.dividend = 32'd1000; bus.divisor = 16'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk++;
        if (bus.busy !== 1'b1) $display("FAIL busy_rise got %b want 1", bus.busy);
        else pass++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin dones++; at = n; end
            if (n == 10) begin
                chk++;
                if (bus.quo !== 32'd0 || bus.dz !== 1'b1) $display("FAIL hold_outputs got %h dz %b want 0 dz 1", bus.quo, bus.dz);
                else pass++;
                bus.dividend = 32'd77; bus.divisor = 16'd3; bus.start = 1'b1;
            end
            if (n == 11) bus.start = 1'b0;
        end
        chk++;
        if (dones !== 1 || at !== 33) $display("FAIL busy_start_dones got %0d at %0d want 1 at 33", dones, at);
        else pass++;
        chk++;
        if (bus.quo !== 32'd142 || bus.rem !== 16'd6 || bus.dz !== 1'b0) $display("FAIL busy_start_result got %h/%h dz %b want 0000008e/0006 dz 0", bus.quo, bus.rem, bus.dz);
        else pass++;
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        int lat;
        bus.dividend = 32'd1000; bus.divisor = 16'hFFF9; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk++;
        if ({bus.busy, bus.done, bus.dz, bus.ovf} !== 4'b0 || {bus.quo, bus.rem} !== 48'h0) $display("FAIL mid_reset got busy %b done %b %h/%h want all 0", bus.busy, bus.done, bus.quo, bus.rem);
        else pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk++;
        if (dones !== 0) $display("FAIL mid_reset_done got %0d want 0", dones);
        else pass++;
        run(-32'sd1000, 16'hFFF9, lat);
        chk++;
        if (bus.quo !== 32'd142 || bus.rem !== 16'hFFFA || lat !== 33) $display("FAIL after_reset got %h/%h lat %0d want 0000008e/fffa lat 33", bus.quo, bus.rem, lat);
        else pass++;
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] a;
        logic [15:0] b;
        logic signed [31:0] sa, sb, eq, er;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = 16'($urandom);
            if (i % 8 == 1) a = 32'h80000000;
            if (i % 8 == 2) a = 32'h7FFFFFFF;
            if (i % 16 == 3) b = 16'h8000;
            if (b == 16'd0) b = 16'd1;
            if (a == 32'h80000000 && b == 16'hFFFF) b = 16'd3;
            sa = a;
            sb = {{16{b[15]}}, b};
            eq = sa / sb;
            er = sa % sb;
            run(a, b, lat);
            chk++;
            if ({bus.quo, bus.rem, bus.dz, bus.ovf} !== {eq, er[15:0], 2'b00} || lat !== 33)
                $display("FAIL random %h/%h got %h/%h dz %b ovf %b lat %0d want %h/%h", a, b, bus.quo, bus.rem, bus.dz, bus.ovf, lat, eq, er[15:0]);
            else pass++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signs;
        test_overflow;
        test_div_zero;
        test_start_while_busy;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule

// File: doc/div_seq_32by16.md
# div_seq_32by16

Sequential signed restoring divider: the inverse datapath of the team's 16x16 signed multiplier. It takes a 2*BIT-bit signed dividend (a full multiplier product) and a BIT-bit signed divisor. It returns the truncated signed quotient and remainder after a fixed number of cycles, with a start/done handshake. It sits beside the multiplier in the arithmetic test datapath, so that products can be divided back for error and approximation checking.

## Interface
- BIT, 16, divisor width; dividend and quotient are 2*BIT wide.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- dividend  input  2*BIT  signed two's-complement dividend.
- divisor  input  BIT  signed two's-complement divisor.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- quo  output  2*BIT  signed quotient, truncated toward zero.
- rem  output  BIT  signed remainder; carries the sign of the dividend.
- dz  output  1  divide-by-zero flag; valid with done.
- ovf  output  1  quotient overflow flag; valid with done.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE, start=1, divisor!=0:**
  - Register magnitudes |dividend| (2*BIT bits, unsigned) and |divisor| (BIT bits, unsigned).
  - Register sq = dividend[MSB]^divisor[MSB] and sr = dividend[MSB].
  - Clear the partial remainder (BIT+1 bits) and set the counter to 2*BIT-1. Go to CALC.
- **IDLE, start=1, divisor==0:** go to FIX with the dz condition latched; no iterations run.
- **CALC, one iteration per cycle (restoring):**
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Compute trial = partial remainder - |divisor|.
  - If trial is non-negative, keep trial and shift in quotient bit 1; otherwise keep the partial remainder and shift in 0.
  - When the counter reaches 0, go to FIX. Otherwise decrement the counter.
- **FIX:**
  - quo = sq ? -Qmag : Qmag, and rem = sr ? -Rmag : Rmag, both two's complement.
  - Register quo, rem, dz and ovf, assert done, and return to IDLE.
- **Width rules:**
  - The magnitude of -2^(2*BIT-1) is 2^(2*BIT-1) and fits the unsigned register. The magnitude of divisor -2^(BIT-1) likewise fits.
  - |rem| < |divisor| ≤ 2^(BIT-1), so rem always fits BIT bits signed.
- **ovf = 1** when Qmag = 2^(2*BIT-1) and sq = 0; the only case is -2^31 / -1. quo then wraps to 0x80000000.
- **Divide by zero:** dz=1, ovf=0, quo=0, rem=0.
- **start while busy:** ignored; no queuing, no error.
- **Output hold:** quo, rem, dz and ovf hold their values until the next done. They do not change during a later computation.

## Timing
- **Reset values:** state IDLE, busy=0, done=0, quo=0, rem=0, dz=0, ovf=0. The counter and internal registers are 0.
- **Normal case:** start is sampled at edge E0 and busy goes high after E0. Iterations occur at edges E1..E2*BIT (E1..E32 for BIT=16). FIX registers the result at E2*BIT+1 (E33).
  - done and the new outputs are visible in the cycle following E33, so latency is 33 cycles from the start edge.
  - busy falls at E33, in the same cycle that done is high.
- **Divide by zero:** done at E1, latency 1 cycle; busy is high for the single cycle between E0 and E1.
- **Back-to-back requests:** a new start can be sampled at the edge after done (E34), giving a throughput of one division per 34 cycles.
- **Reset mid-operation:** rst_n low clears everything immediately, with no done pulse. The first start after release is handled normally.

## Structure
- Package div_pkg holds:
  - the BIT default;
  - the state enum {IDLE, CALC, FIX};
  - the counter width, $clog2(2*BIT).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder and quotient bit.
- The top module keeps the FSM, the counter, sign handling and the output registers.

## Test plan
- dividend=1000, divisor=7 -> quo=142, rem=6, dz=0, ovf=0; done exactly 33 cycles after the start edge and high for one cycle.
- dividend=-1000, divisor=7 -> quo=-142 (0xFFFFFF72), rem=-6 (0xFFFA); dividend=1000, divisor=-7 -> quo=-142, rem=6.
- dividend=0x80000000, divisor=0xFFFF -> quo=0x80000000, ovf=1; dividend=0x80000000, divisor=0x8000 -> quo=65536, rem=0, ovf=0.
- dividend=5, divisor=0 -> done 1 cycle after start, dz=1, quo=0, rem=0; previous outputs are overwritten only at done.
- start pulsed again at cycle 10 of a division -> ignored, with one done only and the first result intact. Then rst_n is pulsed low at cycle 10 of another division -> busy=0, no done, all outputs 0; the next division is correct.
- Randomized operands (1000+) against a reference model using signed / and %, excluding divisor 0 and checking ovf separately.
